// File: rtl/tff_ctrl_pkg.sv
// tff_ctrl_pkg: shared types and constants for the T-flip-flop counter
// controller.
//   state_t : controller FSM state (IDLE / RUN / DONE)
//   t_op_e  : selects which toggle vector the controller drives this cycle
//   DIR_UP / DIR_DOWN : encoding of the dir input
package tff_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,  // t = 0, bank keeps its value
    OP_STEP = 2'b01,  // t = ripple-carry (up) or ripple-borrow (down)
    OP_LOAD = 2'b10   // t = count ^ start value, bank jumps to start value
  } t_op_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tff_bit.sv
// tff_bit: a single T-type flip-flop.
//   clk  : clock, state changes on the falling edge
//   rs_n : synchronous active-low clear
//   t    : toggle enable; q flips when t=1
//   q    : stored bit
module tff_bit (
  input  logic clk,
  input  logic rs_n,
  input  logic t,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q ^ t;
  end

  always_ff @(negedge clk) begin
    if (!rs_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/tff_count_ctrl.sv
// tff_count_ctrl: sequencing controller for a bank of WIDTH T flip-flops
// forming a modulo-N up/down counter. The controller only produces the
// per-bit toggle vector; the count itself lives in the tff_bit cells.
//   clk     : clock, all state updates on the falling edge
//   rs_n    : synchronous active-low reset
//   start   : begin / restart a run (wins over stop)
//   stop    : abort a run without done
//   dir     : 0 = up, 1 = down (latched at start)
//   cont    : 1 = continuous wrap, 0 = one-shot (latched at start)
//   mod_val : modulus N, 0 encodes 2^WIDTH (latched at start)
//   count   : flip-flop bank contents
//   busy    : state is RUN
//   done    : one-cycle pulse after a one-shot run completes
//   wrap    : one-cycle pulse coincident with a continuous-mode reload
module tff_count_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rs_n,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             cont,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic             cont_q, cont_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic             wrap_q, wrap_d;

  t_op_e            op;
  logic             load_dir;
  logic [WIDTH-1:0] load_mod;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] term_val;
  logic             at_term;
  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] t_down;
  logic [WIDTH-1:0] t;

  // Ripple carry / borrow prefixes: bit i toggles when every lower bit is
  // 1 (counting up) or 0 (counting down).
  assign t_up[0]   = 1'b1;
  assign t_down[0] = 1'b1;
  for (genvar gi = 1; gi < WIDTH; gi++) begin : g_prefix
    assign t_up[gi]   = t_up[gi-1] & count[gi-1];
    assign t_down[gi] = t_down[gi-1] & ~count[gi-1];
  end

  // N-1 with WIDTH-bit wraparound, so mod 0 (N = 2^WIDTH) yields all ones.
  assign load_val = (load_dir == DIR_DOWN) ? (load_mod - ONE) : ZERO;
  assign term_val = (dir_q == DIR_DOWN) ? ZERO : (mod_q - ONE);
  assign at_term  = (count == term_val);

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    cont_d   = cont_q;
    mod_d    = mod_q;
    wrap_d   = 1'b0;
    op       = OP_HOLD;
    // A continuous reload uses the latched config; a fresh start uses the
    // live inputs so the load lands on the same edge as the latch.
    load_dir = dir_q;
    load_mod = mod_q;

    if (start) begin
      dir_d    = dir;
      cont_d   = cont;
      mod_d    = mod_val;
      load_dir = dir;
      load_mod = mod_val;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          op      = OP_LOAD;
          state_d = RUN;
        end
      end
      RUN: begin
        if (start) begin
          op = OP_LOAD;
        end else if (stop) begin
          state_d = IDLE;
        end else if (at_term) begin
          if (cont_q) begin
            op     = OP_LOAD;
            wrap_d = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else begin
          op = OP_STEP;
        end
      end
      DONE: begin
        if (start) begin
          op      = OP_LOAD;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    t = ZERO;
    case (op)
      OP_STEP: t = (dir_q == DIR_DOWN) ? t_down : t_up;
      OP_LOAD: t = count ^ load_val;
      default: t = ZERO;
    endcase
  end

  always_ff @(negedge clk) begin
    if (!rs_n) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      cont_q  <= 1'b0;
      mod_q   <= ZERO;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cont_q  <= cont_d;
      mod_q   <= mod_d;
      wrap_q  <= wrap_d;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bank
    tff_bit u_bit (
      .clk  (clk),
      .rs_n (rs_n),
      .t    (t[gi]),
      .q    (count[gi])
    );
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign wrap = wrap_q;

endmodule

// File: doc/tff_count_ctrl.md
# tff_count_ctrl

Sequencing controller for a bank of toggle flip-flops forming a synchronous modulo-N counter. All count state lives in WIDTH T-type bit cells. The controller computes only the per-bit toggle vector each cycle, for step, wrap and reload alike. It sits between the control logic that requests count runs (start/stop, direction, modulus, one-shot or continuous) and the flip-flop bank, and reports busy/done/wrap status.

## Interface
- WIDTH, 4: number of T-flip-flop bits; count range 0..2^WIDTH-1.
- clk  in  1  clock; all state updates on the falling edge.
- rs_n  in  1  reset, synchronous, active-low; sampled on the falling edge of clk.
- start  in  1  level, sampled per edge; begins or restarts a run.
- stop  in  1  level; aborts a run.
- dir  in  1  0 = up, 1 = down; latched at start.
- cont  in  1  1 = continuous (wrap forever), 0 = one-shot; latched at start.
- mod_val  in  WIDTH  modulus N, latched at start; 0 encodes N = 2^WIDTH.
- count  out  WIDTH  flip-flop bank contents.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse on one-shot completion.
- wrap  out  1  one-cycle pulse on a continuous-mode reload.

## Operation
- States: IDLE, RUN, DONE.
- Bit i next value = count[i] XOR t[i]. The controller never writes count directly.
- Start value: up = 0; down = N-1. Terminal value: up = N-1; down = 0.
- Load: t = count XOR start_value.
- Step up: t[i] = AND of count[i-1:0] (t[0]=1).
- Step down: t[i] = AND of ~count[i-1:0] (t[0]=1).
- Hold: t = 0.
- IDLE:
  - Hold.
  - start → latch dir/cont/mod_val, load start value, go RUN.
- RUN, priority order:
  1. start → re-latch and reload; stay RUN.
  2. stop → hold, go IDLE; no done.
  3. count == terminal and cont=1 → load start value, wrap=1.
  4. count == terminal and cont=0 → hold, go DONE.
  5. Otherwise step.
- DONE:
  - done=1 for exactly one cycle; hold.
  - Next edge → IDLE, or RUN with load if start=1.
- start with stop on the same edge: start wins everywhere.
- N=1: start and terminal are both 0.
  - Continuous: count stays 0, wrap every cycle.
  - One-shot: DONE on the first RUN edge.
- mod_val changes during RUN have no effect until the next start.
- Reset: state IDLE, count 0, busy 0, done 0, wrap 0, latched dir/cont 0, latched mod 0. Reset overrides start in the same edge and aborts any run.

## Timing
- Outputs are registered and change only after a falling clk edge. No combinational path from inputs to outputs.
- start→count = start value: 1 edge. First step: 2nd edge.
- One-shot up, N: count reaches N-1 at edge N after start. done is high after edge N+1. busy falls on the same edge.
- wrap is high in the cycle after the reload edge, coincident with count = start value.
- stop latency: 1 edge to busy=0. count is frozen from that edge.
- busy = (state==RUN). done = (state==DONE). Both are direct decodes of the state register.

## Structure
- Package tff_ctrl_pkg holds:
  - state typedef (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
  - DIR_UP=1'b0, DIR_DOWN=1'b1.
- Sub-module tff_bit: one T flip-flop.
  - Falling-edge clk, synchronous active-low clear from rs_n.
  - Generate-instantiated WIDTH times.
  - Driven by t[i]; outputs form count.
- Controller RTL: FSM, latched config, terminal compare, toggle-vector mux (hold/step-up/step-down/load).

## Test plan (WIDTH=4)
- Reset mid-run at count=7, rs_n low 2 edges → count=0, busy=0, done=0, wrap=0; start held during reset is ignored.
- Up one-shot, mod_val=10 → count 0..9 on edges 1..10 after start. done pulse after edge 11. busy falls with it. wrap never asserted.
- Down continuous, mod_val=5 → 4,3,2,1,0,4,3… wrap high only in cycles showing the reloaded 4. Checker asserts t == count XOR next count every edge.
- mod_val=0, up continuous → 0..15 then 0 with wrap. Down from start → 15 first.
- stop at count=6 → next edge busy=0, count=6 held, no done.
  - start+stop together in RUN → reload to 0, busy stays 1.
  - start in DONE → reload without IDLE visit.
- mod_val=1: continuous → count 0, wrap every cycle. One-shot → done two edges after start.
